mac_seq_ctrl: RTL and testbench

Sequencer that drives one mac_unit instance to compute a dot product over a stream of weight/input pairs. The running accumulator is held in a register that feeds partial_sum_in each step. Bounded by start/vec_len on the command side, valid/ready on the operand stream, and valid/ready on the result. Sits between the operand buffers and the output collector in the MAC array; the datapath stays combinational inside mac_unit.

---
 rtl/mac_pkg.sv | 14 +
 rtl/mac_unit.sv | 26 ++
 rtl/mac_seq_ctrl.sv | 98 +++++++++
 tb/tb_mac_seq_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and default sizing for the MAC sequencer and its datapath.
package mac_pkg;

  localparam int unsigned DefBitWidth  = 8;
  localparam int unsigned DefAccumBits = 20;
  localparam int unsigned DefLenBits   = 8;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDone
  } mac_state_e;

endpackage

// File: rtl/mac_unit.sv
// Combinational multiply-accumulate: partial_sum_out = partial_sum_in + weight * inp (unsigned).
module mac_unit
  import mac_pkg::*;
#(
  parameter int unsigned BIT_WIDTH  = DefBitWidth,
  parameter int unsigned ACCUM_BITS = DefAccumBits
) (
  input  logic [BIT_WIDTH-1:0]  weight,
  input  logic [BIT_WIDTH-1:0]  inp,
  input  logic [ACCUM_BITS-1:0] partial_sum_in,
  output logic [ACCUM_BITS-1:0] partial_sum_out
);

  logic [ACCUM_BITS-1:0] product;

  if (ACCUM_BITS < 2 * BIT_WIDTH) begin : g_bad_width
    $error("mac_unit: ACCUM_BITS must be at least 2*BIT_WIDTH");
  end

  // Operands widened first so the full product fits; the sum wraps modulo 2^ACCUM_BITS.
  always_comb begin
    product         = ACCUM_BITS'(weight) * ACCUM_BITS'(inp);
    partial_sum_out = partial_sum_in + product;
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencer that streams weight/input pairs through one mac_unit to form a biased dot product.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int unsigned BIT_WIDTH  = DefBitWidth,
  parameter int unsigned ACCUM_BITS = DefAccumBits,
  parameter int unsigned LEN_BITS   = DefLenBits
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_BITS-1:0]   vec_len,
  input  logic [ACCUM_BITS-1:0] bias,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIT_WIDTH-1:0]  weight,
  input  logic [BIT_WIDTH-1:0]  inp,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACCUM_BITS-1:0] result,
  output logic                  busy
);

  mac_state_e            state_q, state_d;
  logic [ACCUM_BITS-1:0] acc_q, acc_d;
  logic [LEN_BITS-1:0]   len_q, len_d;
  logic [LEN_BITS-1:0]   count_q, count_d;
  logic [ACCUM_BITS-1:0] mac_sum;
  logic                  last_pair;

  mac_unit #(
    .BIT_WIDTH  (BIT_WIDTH),
    .ACCUM_BITS (ACCUM_BITS)
  ) u_mac_unit (
    .weight          (weight),
    .inp             (inp),
    .partial_sum_in  (acc_q),
    .partial_sum_out (mac_sum)
  );

  // len_q is never zero in StAccum, so len_q - 1 cannot wrap.
  assign last_pair = (count_q == (len_q - LEN_BITS'(1)));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    len_d   = len_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d   = bias;
          len_d   = vec_len;
          count_d = '0;
          state_d = (vec_len == '0) ? StDone : StAccum;
        end
      end
      StAccum: begin
        if (in_valid) begin
          acc_d   = mac_sum;
          count_d = count_q + LEN_BITS'(1);
          if (last_pair) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      len_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      len_q   <= len_d;
      count_q <= count_d;
    end
  end

  // Handshake outputs decode state only, never the incoming valid/ready.
  always_comb begin
    in_ready  = (state_q == StAccum);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    result    = acc_q;
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with hand-computed dot products.
module tb_mac_seq_ctrl;

  localparam int unsigned BW = 8;
  localparam int unsigned AB = 20;
  localparam int unsigned LB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [LB-1:0] vec_len;
  logic [AB-1:0] bias;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] weight;
  logic [BW-1:0] inp;
  logic          out_valid;
  logic          out_ready;
  logic [AB-1:0] result;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  mac_seq_ctrl #(
    .BIT_WIDTH  (BW),
    .ACCUM_BITS (AB),
    .LEN_BITS   (LB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .vec_len   (vec_len),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .weight    (weight),
    .inp       (inp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a vector of n identical pairs (w,x), stream them back to back, check and drain the result.
  task automatic run_rep(input string tag, input logic [AB-1:0] b, input logic [LB-1:0] n,
                         input logic [BW-1:0] w, input logic [BW-1:0] x,
                         input logic [AB-1:0] exp);
    start = 1'b1; vec_len = n; bias = b;
    step();
    start = 1'b0;
    for (int k = 0; k < int'(n); k++) begin
      check({tag, "_in_ready"}, in_ready, 1);
      check({tag, "_no_out_valid"}, out_valid, 0);
      in_valid = 1'b1; weight = w; inp = x;
      step();
    end
    in_valid = 1'b0;
    check({tag, "_out_valid"}, out_valid, 1);
    check({tag, "_result"}, result, exp);
    check({tag, "_in_ready_low"}, in_ready, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_out_valid"}, out_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; vec_len = '0; bias = '0;
    in_valid = 1'b0; weight = '0; inp = '0; out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);

    // Basic dot product: 10 + 2*3 + 4*5 + 1*1 = 37.
    start = 1'b1; vec_len = 4'd3; bias = 20'd10;
    step();
    start = 1'b0;
    check("basic_in_ready", in_ready, 1);
    check("basic_busy", busy, 1);
    in_valid = 1'b1; weight = 8'd2; inp = 8'd3;
    step();
    check("basic_mid1_out_valid", out_valid, 0);
    weight = 8'd4; inp = 8'd5;
    step();
    check("basic_mid2_out_valid", out_valid, 0);
    weight = 8'd1; inp = 8'd1;
    step();
    in_valid = 1'b0;
    check("basic_out_valid", out_valid, 1);
    check("basic_result", result, 37);
    check("basic_done_busy", busy, 1);
    check("basic_done_in_ready", in_ready, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("basic_idle_out_valid", out_valid, 0);
    check("basic_idle_busy", busy, 0);

    // Zero length: result is the bias one cycle after start.
    run_rep("zero_len", 20'd5, 4'd0, 8'd0, 8'd0, 20'd5);

    // Gaps in the operand stream, stray starts, result backpressure: 3*3 + 2*7 = 23.
    start = 1'b1; vec_len = 4'd2; bias = 20'd0;
    step();
    start = 1'b0;
    in_valid = 1'b1; weight = 8'd3; inp = 8'd3;
    step();
    in_valid = 1'b0; weight = 8'd99; inp = 8'd99; start = 1'b1; vec_len = 4'd0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("gap_in_ready", in_ready, 1);
      check("gap_out_valid", out_valid, 0);
    end
    start = 1'b0;
    in_valid = 1'b1; weight = 8'd2; inp = 8'd7;
    step();
    in_valid = 1'b0; start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_result", result, 23);
      step();
    end
    start = 1'b0;
    check("bp_out_valid_last", out_valid, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_idle_busy", busy, 0);
    check("bp_idle_out_valid", out_valid, 0);
    step();
    check("bp_no_restart", busy, 0);

    // Accumulator wraps modulo 2^20.
    run_rep("wrap1", 20'hFFFFF, 4'd1, 8'd1, 8'd1, 20'd0);
    run_rep("wrap2", 20'hFFFFE, 4'd1, 8'd255, 8'd255, 20'd65023);

    // Reset after 2 of 4 handshakes discards the vector.
    start = 1'b1; vec_len = 4'd4; bias = 20'd100;
    step();
    start = 1'b0;
    in_valid = 1'b1; weight = 8'd1; inp = 8'd1;
    step();
    step();
    in_valid = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_result", result, 0);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("midrst_stay_idle", busy, 0);
      check("midrst_no_out_valid", out_valid, 0);
    end
    in_valid = 1'b0;
    run_rep("after_rst", 20'd0, 4'd1, 8'd6, 8'd7, 20'd42);

    // Maximum length for a 4-bit counter: 15 pairs without wrap.
    run_rep("max_len", 20'd0, 4'd15, 8'd1, 8'd1, 20'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
